relu_maxpool2x2: RTL and testbench
==================================

Name: relu_maxpool2x2

Overview:
- Downstream stage of the 3x3 convolution PE.
- Consumes the PE's raster-order stream of signed conv results and applies ReLU.
- Performs a 2x2, stride-2 max-pool and emits one pooled pixel per 2x2 window.
- Output feeds the next layer's data input.
- Uses a half-row line buffer, so pooling runs at stream rate with no frame buffer.

Parameters:
- WIDTH, 9: data width, signed two's complement; matches the PE data width.
- IMG_W, 8: conv output row length in pixels; must be even and >= 2.
- IMG_H, 8: conv output rows per frame; must be even and >= 2.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- in_valid  in  1  in_data carries a conv result this cycle
- in_data  in  WIDTH  signed conv result, raster order, row-major
- out_valid  out  1  out_data holds a pooled pixel; single-cycle pulse
- out_data  out  WIDTH  pooled result, always >= 0
- out_last  out  1  high together with out_valid on the final pooled pixel of a frame

Behaviour:
- Reset (rst_n low at a clk edge):
  - col, row cleared to 0; out_valid, out_data, out_last cleared to 0.
  - Line-buffer contents are don't-care; every entry is rewritten before it is read.
  - Reset mid-frame discards the partial frame; the next in_valid beat is pixel (0,0).
- No backpressure: every in_valid beat is accepted.
- in_valid gaps of any length are allowed; state advances only on in_valid beats.
- ReLU: r = (in_data < 0) ? 0 : in_data, using the signed compare on the MSB.
  - ReLU before max gives the same result as max then ReLU.
  - All comparisons are on ReLU'd values, so they are unsigned WIDTH-1 magnitudes.
- Counters:
  - col runs 0..IMG_W-1 and row runs 0..IMG_H-1, both advancing on in_valid.
  - col wraps to 0 and increments row at IMG_W-1.
  - row wraps to 0 at IMG_H-1; a new frame starts immediately with no gap cycle.
- Horizontal pair:
  - Even col: hreg <= r.
  - Odd col: pair = max(hreg, r).
- Even row, odd col: linebuf[col>>1] <= pair. No output.
- Odd row, odd col:
  - Next cycle: out_data <= max(linebuf[col>>1], pair), out_valid <= 1.
  - out_last <= (row == IMG_H-1 && col == IMG_W-1).
- Latency: out_valid rises exactly 1 clk after the accepted beat that completes the window (bottom-right pixel).
- Throughput: (IMG_W/2)*(IMG_H/2) outputs per frame. Outputs are in raster order of the pooled map.
- out_valid and out_last are 0 on every other cycle. out_data holds its last value when out_valid is 0.
- Line buffer:
  - IMG_W/2 entries x WIDTH.
  - Write on even rows, read on odd rows at the same address.
  - Never read and written in the same cycle, so no bypass is required.
- Equal operands: either operand may be selected; the value is identical.
- Frame wrap: last beat of frame N and first beat of frame N+1 may be on consecutive cycles.
  - out_last for frame N coincides with frame N+1's pixel (0,0) being accepted.
  - No interference between the two.

Decomposition:
- Shared CNN package/include:
  - data WIDTH default (9), shared with the PE.
  - Pooling factor constant (2).
  - relu and signed max helper functions.
- Sub-module pool_line_buf: a simple dual-port register array.
  - Depth IMG_W/2, width WIDTH.
  - Synchronous write, combinational read.
- Counters and compare logic stay in relu_maxpool2x2.

Test Plan (IMG_W=4, IMG_H=4, WIDTH=9 unless noted):
- Ascending frame: in_valid every cycle with values 0..15.
  - Expect outputs 5, 7, 13, 15.
  - Each output 1 clk after the input beats carrying 5, 7, 13, 15.
  - out_last only with 15.
- All-negative frame: 16 beats of -3 (0x1FD).
  - Expect four outputs of 0, with out_last on the 4th.
- Signed extremes: one window of {-256, 255, 0, -1}, all other pixels 1.
  - Expect that window's output = 255 and the other windows = 1.
- Gapped input: the ascending frame with in_valid high every other cycle.
  - Same outputs 5, 7, 13, 15, each 1 clk after its bottom-right beat.
  - out_valid never high on an idle-input cycle + 1.
- Reset mid-frame: 6 beats of value 100, rst_n low for 1 cycle, then the ascending frame.
  - Exactly 4 outputs: 5, 7, 13, 15. No 100 appears.
- Back-to-back frames: the ascending frame immediately followed by frame values 15..0.
  - Outputs 5, 7, 13, 15, then 15, 13, 7, 5.
  - out_last high exactly twice.

Source files
------------

// File: rtl/relu_maxpool2x2_pkg.sv
// rtl/relu_maxpool2x2_pkg.sv - shared CNN datapath constants and ReLU/max helpers
//
// Purpose : data width shared with the 3x3 conv PE, the pooling factor, and
//           the ReLU / signed-max helpers used by the pooling stage.
// Ports   : none (package).
package relu_maxpool2x2_pkg;

    localparam int CNN_WIDTH   = 9;
    localparam int POOL_FACTOR = 2;

    // Helpers work on a wide signed word; callers sign/zero-extend in and
    // truncate the result back to their own data width.
    localparam int HELPER_W = 32;

    function automatic logic signed [HELPER_W-1:0] relu(
        input logic signed [HELPER_W-1:0] x
    );
        return x[HELPER_W-1] ? '0 : x;
    endfunction

    function automatic logic signed [HELPER_W-1:0] smax(
        input logic signed [HELPER_W-1:0] a,
        input logic signed [HELPER_W-1:0] b
    );
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/pool_line_buf.sv
// rtl/pool_line_buf.sv - half-row line buffer for the 2x2 max-pool
//
// Purpose : simple dual-port register array holding one horizontal-pair max
//           per pooled column of the previous (even) row.
// Ports   : clk        - clock
//           i_wr_en    - write strobe
//           i_wr_addr  - write address
//           i_wr_data  - write data
//           i_rd_addr  - read address
//           o_rd_data  - combinational read data
module pool_line_buf #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 9,
    parameter int AW    = 2
) (
    input  logic             clk,
    input  logic             i_wr_en,
    input  logic [AW-1:0]    i_wr_addr,
    input  logic [WIDTH-1:0] i_wr_data,
    input  logic [AW-1:0]    i_rd_addr,
    output logic [WIDTH-1:0] o_rd_data
);

    // No reset: every entry is written on an even row before the odd row reads it.
    logic [WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/relu_maxpool2x2.sv
// rtl/relu_maxpool2x2.sv - ReLU followed by 2x2 stride-2 max-pool on a raster stream
//
// Purpose : consumes the conv PE's raster-order signed results, applies ReLU
//           and emits one pooled pixel per 2x2 window, one clock after the
//           beat that completes the window.
// Ports   : clk       - clock
//           rst_n     - synchronous active-low reset
//           in_valid  - in_data carries a conv result this cycle
//           in_data   - signed conv result, raster order
//           out_valid - single-cycle pulse, out_data holds a pooled pixel
//           out_data  - pooled result (always >= 0), held between pulses
//           out_last  - final pooled pixel of the frame
module relu_maxpool2x2
    import relu_maxpool2x2_pkg::*;
#(
    parameter int WIDTH = CNN_WIDTH,
    parameter int IMG_W = 8,
    parameter int IMG_H = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             out_last
);

    localparam int HALF = IMG_W / POOL_FACTOR;
    localparam int CW   = (IMG_W > 2) ? $clog2(IMG_W) : 1;
    localparam int RW   = (IMG_H > 2) ? $clog2(IMG_H) : 1;
    localparam int AW   = (HALF > 1) ? $clog2(HALF) : 1;

    logic [CW-1:0]    r_col;
    logic [RW-1:0]    r_row;
    logic [WIDTH-1:0] r_hreg;
    logic             r_out_valid;
    logic [WIDTH-1:0] r_out_data;
    logic             r_out_last;

    logic [WIDTH-1:0] w_r;
    logic [WIDTH-1:0] w_pair;
    logic [WIDTH-1:0] w_lb_rd;
    logic [WIDTH-1:0] w_pool;
    logic [AW-1:0]    w_addr;
    logic             w_col_last;
    logic             w_row_last;
    logic             w_lb_wr;
    logic             w_emit;

    // After ReLU every value is non-negative, so zero-extension into the
    // signed helper keeps the compare correct.
    assign w_r    = WIDTH'(relu({{(HELPER_W-WIDTH){in_data[WIDTH-1]}}, in_data}));
    assign w_pair = WIDTH'(smax(HELPER_W'(r_hreg), HELPER_W'(w_r)));
    assign w_pool = WIDTH'(smax(HELPER_W'(w_lb_rd), HELPER_W'(w_pair)));

    assign w_addr     = AW'(r_col >> 1);
    assign w_col_last = (r_col == CW'(IMG_W - 1));
    assign w_row_last = (r_row == RW'(IMG_H - 1));

    // Even rows store the pair max, odd rows consume it at the same address,
    // so the buffer is never read and written on the same beat.
    assign w_lb_wr = in_valid && r_col[0] && !r_row[0];
    assign w_emit  = in_valid && r_col[0] &&  r_row[0];

    pool_line_buf #(
        .DEPTH (HALF),
        .WIDTH (WIDTH),
        .AW    (AW)
    ) u_line_buf (
        .clk       (clk),
        .i_wr_en   (w_lb_wr),
        .i_wr_addr (w_addr),
        .i_wr_data (w_pair),
        .i_rd_addr (w_addr),
        .o_rd_data (w_lb_rd)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_col       <= '0;
            r_row       <= '0;
            r_hreg      <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_last  <= 1'b0;
        end else begin
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            if (in_valid) begin
                if (!r_col[0]) begin
                    r_hreg <= w_r;
                end
                if (w_emit) begin
                    r_out_valid <= 1'b1;
                    r_out_data  <= w_pool;
                    r_out_last  <= w_row_last && w_col_last;
                end
                // Frame wrap needs no idle cycle: next beat is pixel (0,0).
                if (w_col_last) begin
                    r_col <= '0;
                    if (w_row_last) begin
                        r_row <= '0;
                    end else begin
                        r_row <= r_row + RW'(1);
                    end
                end else begin
                    r_col <= r_col + CW'(1);
                end
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_last  = r_out_last;

endmodule

// File: tb/tb_relu_maxpool2x2.sv
// tb/tb_relu_maxpool2x2.sv - directed table-driven bench for relu_maxpool2x2
module tb_relu_maxpool2x2;

    localparam int WIDTH = 9;
    localparam int IMG_W = 4;
    localparam int IMG_H = 4;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic             out_last;

    int checks;
    int errors;
    int n_valid;
    int n_last;
    int n_hundred;

    typedef struct {
        logic             vin;
        logic [WIDTH-1:0] din;
        logic             ev;
        logic [WIDTH-1:0] ed;
        logic             el;
    } vec_t;

    vec_t vq[$];

    relu_maxpool2x2 #(
        .WIDTH (WIDTH),
        .IMG_W (IMG_W),
        .IMG_H (IMG_H)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_last  (out_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input logic vin, input logic [WIDTH-1:0] din,
                       input logic ev, input logic [WIDTH-1:0] ed, input logic el);
        vec_t v;
        v.vin = vin;
        v.din = din;
        v.ev  = ev;
        v.ed  = ed;
        v.el  = el;
        vq.push_back(v);
    endtask

    // Window-completing beats of a 4x4 frame are raster indices 5, 7, 13, 15.
    function automatic logic is_br(input int i);
        return (i == 5) || (i == 7) || (i == 13) || (i == 15);
    endfunction

    task automatic add_asc(input logic gap);
        for (int i = 0; i < 16; i++) begin
            add(1'b1, WIDTH'(i), is_br(i), WIDTH'(i), i == 15);
            if (gap) add(1'b0, '0, 1'b0, '0, 1'b0);
        end
    endtask

    task automatic add_desc();
        logic [WIDTH-1:0] exp_out [4];
        int k;
        exp_out[0] = 9'd15;
        exp_out[1] = 9'd13;
        exp_out[2] = 9'd7;
        exp_out[3] = 9'd5;
        k = 0;
        for (int i = 0; i < 16; i++) begin
            add(1'b1, WIDTH'(15 - i), is_br(i), is_br(i) ? exp_out[k] : '0, i == 15);
            if (is_br(i)) k++;
        end
    endtask

    task automatic run_vecs(input string tag);
        for (int i = 0; i < vq.size(); i++) begin
            @(negedge clk);
            in_valid = vq[i].vin;
            in_data  = vq[i].din;
            @(posedge clk);
            #1;
            chk({tag, ".valid"}, {31'd0, out_valid}, {31'd0, vq[i].ev});
            chk({tag, ".last"},  {31'd0, out_last},  {31'd0, vq[i].el});
            if (vq[i].ev) chk({tag, ".data"}, {23'd0, out_data}, {23'd0, vq[i].ed});
            if (out_valid) n_valid++;
            if (out_valid && out_last) n_last++;
            if (out_valid && out_data == 9'd100) n_hundred++;
        end
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = '0;
        vq.delete();
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset.valid", {31'd0, out_valid}, 32'd0);
        chk("reset.data",  {23'd0, out_data},  32'd0);
        chk("reset.last",  {31'd0, out_last},  32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Ascending frame, then an idle cycle to confirm the pulse drops and data holds.
        add_asc(1'b0);
        add(1'b0, '0, 1'b0, '0, 1'b0);
        run_vecs("asc");
        chk("asc.hold", {23'd0, out_data}, 32'd15);

        // All negative: ReLU clamps every window to zero.
        for (int i = 0; i < 16; i++) add(1'b1, 9'h1FD, is_br(i), 9'd0, i == 15);
        run_vecs("neg");

        // Signed extremes in window (0,0), all other pixels 1.
        for (int i = 0; i < 16; i++) begin
            logic [WIDTH-1:0] d;
            d = 9'd1;
            if (i == 0) d = 9'h100;
            if (i == 1) d = 9'h0FF;
            if (i == 4) d = 9'h000;
            if (i == 5) d = 9'h1FF;
            add(1'b1, d, is_br(i), (i == 5) ? 9'd255 : 9'd1, i == 15);
        end
        run_vecs("ext");

        // Gapped input: idle cycle after every beat.
        add_asc(1'b1);
        run_vecs("gap");

        // Reset mid-frame: beat 5 completes window (0,0) before the reset.
        for (int i = 0; i < 6; i++) add(1'b1, 9'd100, i == 5, 9'd100, 1'b0);
        run_vecs("pre_rst");
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("midrst.valid", {31'd0, out_valid}, 32'd0);
        chk("midrst.data",  {23'd0, out_data},  32'd0);
        @(negedge clk);
        rst_n     = 1'b1;
        n_valid   = 0;
        n_hundred = 0;
        add_asc(1'b0);
        run_vecs("post_rst");
        chk("post_rst.count",   n_valid,   32'd4);
        chk("post_rst.no_100",  n_hundred, 32'd0);

        // Back-to-back frames with no gap at the frame boundary.
        n_valid = 0;
        n_last  = 0;
        add_asc(1'b0);
        add_desc();
        add(1'b0, '0, 1'b0, '0, 1'b0);
        run_vecs("b2b");
        chk("b2b.count", n_valid, 32'd8);
        chk("b2b.lasts", n_last,  32'd2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
